// File: rtl/elevator_controller.sv
// Elevator cabin controller: latches floor calls, sweeps in one direction until no calls
// remain ahead, then reverses. Door/engine commands are registered Moore decodes of the state.
module elevator_controller #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int DOOR_DWELL    = 16,
    parameter int TIMEOUT       = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [BUTTONS_WIDTH-1:0]         buttons,
    input  logic                             sensor_up,
    input  logic                             sensor_down,
    input  logic [1:0]                       sensor_door,
    output logic [1:0]                       engine,
    output logic [1:0]                       door,
    output logic [$clog2(BUTTONS_WIDTH)-1:0] floor,
    output logic [BUTTONS_WIDTH-1:0]         pending,
    output logic                             fault,
    output logic [2:0]                       state_dbg
);

    localparam int FW = $clog2(BUTTONS_WIDTH);
    localparam int DW = (DOOR_DWELL > 0) ? $clog2(DOOR_DWELL + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [FW-1:0] TOP_FLOOR  = FW'(BUTTONS_WIDTH - 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DOOR_DWELL);
    localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLOSING   = 3'd1,
        S_MOVE_UP   = 3'd2,
        S_MOVE_DOWN = 3'd3,
        S_OPENING   = 3'd4,
        S_DWELL     = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    state_t                  state, state_n;
    logic                    dir, dir_n;   // 1 = up
    logic [FW-1:0]           floor_n, floor_p1, floor_m1;
    logic [BUTTONS_WIDTH-1:0] pending_n, floor_bit, mask, clr;
    logic [DW-1:0]           dcnt, dcnt_n;
    logic [TW-1:0]           tcnt, tcnt_n;
    logic                    any_above, any_below, timed_out, timed_state, floor_pulse;

    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        dir_n     = dir;
        floor_n   = floor;
        dcnt_n    = dcnt;
        mask      = '0;
        clr       = '0;
        any_above = 1'b0;
        any_below = 1'b0;
        floor_p1  = floor + 1'b1;
        floor_m1  = floor - 1'b1;
        floor_bit = {{(BUTTONS_WIDTH-1){1'b0}}, 1'b1} << floor;
        timed_out = (tcnt == T_LAST);
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            if (pending[i] && (i > int'(floor))) any_above = 1'b1;
            if (pending[i] && (i < int'(floor))) any_below = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (pending[floor]) begin
                    state_n = S_OPENING;
                end else if (dir ? any_above : any_below) begin
                    state_n = S_CLOSING;
                end else if (dir ? any_below : any_above) begin
                    dir_n   = ~dir;
                    state_n = S_CLOSING;
                end
            end
            S_CLOSING: begin
                if (sensor_door == 2'd2) state_n = dir ? S_MOVE_UP : S_MOVE_DOWN;
                else if (timed_out)      state_n = S_FAULT;
            end
            S_MOVE_UP: begin
                // Wrong-direction pulse or a crossing past the top means the shaft sensors lie.
                if (sensor_down || (sensor_up && floor == TOP_FLOOR)) begin
                    state_n = S_FAULT;
                end else if (sensor_up) begin
                    floor_n = floor_p1;
                    if (pending[floor_p1]) state_n = S_OPENING;
                end else if (timed_out) begin
                    state_n = S_FAULT;
                end
            end
            S_MOVE_DOWN: begin
                if (sensor_up || (sensor_down && floor == '0)) begin
                    state_n = S_FAULT;
                end else if (sensor_down) begin
                    floor_n = floor_m1;
                    if (pending[floor_m1]) state_n = S_OPENING;
                end else if (timed_out) begin
                    state_n = S_FAULT;
                end
            end
            S_OPENING: begin
                mask = floor_bit;
                if (sensor_door == 2'd1) begin
                    state_n = S_DWELL;
                    clr     = floor_bit;
                    dcnt_n  = DWELL_LOAD;
                end else if (timed_out) begin
                    state_n = S_FAULT;
                end
            end
            S_DWELL: begin
                // A press for this floor keeps the door open longer instead of queuing a call.
                mask = floor_bit;
                if (buttons[floor]) begin
                    dcnt_n = DWELL_LOAD;
                end else if (dcnt <= DW'(1)) begin
                    dcnt_n  = '0;
                    state_n = S_IDLE;
                end else begin
                    dcnt_n = dcnt - 1'b1;
                end
            end
            S_FAULT: mask = '1;
            default: state_n = S_FAULT;
        endcase

        pending_n   = (pending | (buttons & ~mask)) & ~clr;
        timed_state = (state == S_CLOSING) || (state == S_OPENING) ||
                      (state == S_MOVE_UP) || (state == S_MOVE_DOWN);
        floor_pulse = ((state == S_MOVE_UP) || (state == S_MOVE_DOWN)) && (sensor_up || sensor_down);
        if ((state_n != state) || floor_pulse || !timed_state) tcnt_n = '0;
        else                                                   tcnt_n = tcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            dir     <= 1'b1;
            floor   <= '0;
            pending <= '0;
            dcnt    <= '0;
            tcnt    <= '0;
            engine  <= 2'd0;
            door    <= 2'd0;
            fault   <= 1'b0;
        end else begin
            state   <= state_n;
            dir     <= dir_n;
            floor   <= floor_n;
            pending <= pending_n;
            dcnt    <= dcnt_n;
            tcnt    <= tcnt_n;
            engine  <= 2'd0;
            door    <= 2'd0;
            fault   <= 1'b0;
            case (state_n)
                S_CLOSING:   door   <= 2'd2;
                S_OPENING:   door   <= 2'd1;
                S_MOVE_UP:   engine <= 2'd2;
                S_MOVE_DOWN: engine <= 2'd1;
                S_FAULT:     fault  <= 1'b1;
                default:     ;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller: call service, sweep order, dwell restart,
// timeouts, sensor faults and asynchronous reset.
module tb_elevator_controller;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CLOSING   = 3'd1;
    localparam logic [2:0] ST_MOVE_UP   = 3'd2;
    localparam logic [2:0] ST_MOVE_DOWN = 3'd3;
    localparam logic [2:0] ST_OPENING   = 3'd4;
    localparam logic [2:0] ST_DWELL     = 3'd5;
    localparam logic [2:0] ST_FAULT     = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] buttons;
    logic       sensor_up, sensor_down;
    logic [1:0] sensor_door;
    logic [1:0] engine, door;
    logic [2:0] floor;
    logic [7:0] pending;
    logic       fault;
    logic [2:0] state_dbg;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    elevator_controller #(.BUTTONS_WIDTH(8), .DOOR_DWELL(16), .TIMEOUT(255)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .buttons    (buttons),
        .sensor_up  (sensor_up),
        .sensor_down(sensor_down),
        .sensor_door(sensor_door),
        .engine     (engine),
        .door       (door),
        .floor      (floor),
        .pending    (pending),
        .fault      (fault),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_up();
        sensor_up = 1'b1;
        tick(1);
        sensor_up = 1'b0;
        tick(1);
    endtask

    task automatic pulse_down();
        sensor_down = 1'b1;
        tick(1);
        sensor_down = 1'b0;
        tick(1);
    endtask

    task automatic press(input logic [7:0] b);
        buttons = b;
        tick(1);
        buttons = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_floor", 32'(floor), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_outputs", {27'd0, engine, door, fault}, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        buttons     = '0;
        sensor_up   = 1'b0;
        sensor_down = 1'b0;
        sensor_door = 2'd2;
        tick(2);
        do_reset();

        // Basic call to floor 3; first edge after release sees an empty pending vector.
        press(8'h08);
        check("a_pending", 32'(pending), 32'h08);
        check("a_first_idle", 32'(state_dbg), 32'(ST_IDLE));
        tick(1);
        check("a_closing", 32'(state_dbg), 32'(ST_CLOSING));
        check("a_door_close", 32'(door), 2);
        tick(1);
        check("a_move_up", 32'(state_dbg), 32'(ST_MOVE_UP));
        check("a_engine_up", 32'(engine), 2);
        pulse_up();
        check("a_floor1", 32'(floor), 1);
        pulse_up();
        pulse_up();
        check("a_floor3", 32'(floor), 3);
        check("a_opening", 32'(state_dbg), 32'(ST_OPENING));
        check("a_door_open", 32'(door), 1);
        check("a_engine_stop", 32'(engine), 0);
        sensor_door = 2'd1;
        tick(1);
        check("a_dwell", 32'(state_dbg), 32'(ST_DWELL));
        check("a_served", 32'(pending), 0);
        tick(15);
        check("a_dwell_15", 32'(state_dbg), 32'(ST_DWELL));
        tick(1);
        check("a_idle", 32'(state_dbg), 32'(ST_IDLE));

        // Dwell restart at floor 4; the floor-6 press in the same cycle still latches.
        press(8'h10);
        sensor_door = 2'd2;
        tick(2);
        check("b_move_up", 32'(state_dbg), 32'(ST_MOVE_UP));
        pulse_up();
        check("b_floor4", 32'(floor), 4);
        sensor_door = 2'd1;
        tick(1);
        check("b_dwell", 32'(state_dbg), 32'(ST_DWELL));
        tick(14);
        press(8'h50);
        check("b_no_latch_here", 32'(pending), 32'h40);
        tick(15);
        check("b_dwell_restarted", 32'(state_dbg), 32'(ST_DWELL));
        tick(1);
        check("b_idle", 32'(state_dbg), 32'(ST_IDLE));

        // Sweep order: floor 5 above is served before floor 0 below.
        sensor_door = 2'd2;
        do_reset();
        press(8'h20);
        tick(2);
        check("c_move_up", 32'(state_dbg), 32'(ST_MOVE_UP));
        pulse_up();
        pulse_up();
        press(8'h01);
        check("c_pending", 32'(pending), 32'h21);
        check("c_floor2", 32'(floor), 2);
        for (int k = 0; k < 2; k++) begin
            pulse_up();
            check("c_engine_still_up", 32'(engine), 2);
            check("c_floor_up", 32'(floor), 32'(3 + k));
        end
        pulse_up();
        check("c_floor5", 32'(floor), 5);
        check("c_open5", 32'(state_dbg), 32'(ST_OPENING));
        sensor_door = 2'd1;
        tick(1);
        check("c_served5", 32'(pending), 32'h01);
        tick(16);
        check("c_idle5", 32'(state_dbg), 32'(ST_IDLE));
        tick(1);
        check("c_closing_rev", 32'(state_dbg), 32'(ST_CLOSING));
        sensor_door = 2'd2;
        tick(1);
        check("c_engine_down", 32'(engine), 1);
        for (int k = 0; k < 4; k++) pulse_down();
        check("c_floor1", 32'(floor), 1);
        check("c_still_down", 32'(state_dbg), 32'(ST_MOVE_DOWN));
        pulse_down();
        check("c_floor0", 32'(floor), 0);
        check("c_open0", 32'(state_dbg), 32'(ST_OPENING));
        sensor_door = 2'd1;
        tick(1);
        check("c_served0", 32'(pending), 0);

        // Reset mid descent stops the engine without a clock edge.
        sensor_door = 2'd2;
        do_reset();
        press(8'h02);
        tick(2);
        pulse_up();
        check("d_open1", 32'(state_dbg), 32'(ST_OPENING));
        sensor_door = 2'd1;
        tick(1);
        press(8'h01);
        tick(15);
        check("d_idle", 32'(state_dbg), 32'(ST_IDLE));
        tick(1);
        sensor_door = 2'd2;
        tick(1);
        check("d_engine_down", 32'(engine), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("d_async_engine", 32'(engine), 0);
        check("d_async_floor", 32'(floor), 0);
        check("d_async_pending", 32'(pending), 0);
        check("d_async_state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick(1);

        // CLOSING timeout: 254 cycles still closing, the 255th faults.
        sensor_door = 2'd0;
        press(8'h08);
        tick(1);
        check("e_closing", 32'(state_dbg), 32'(ST_CLOSING));
        tick(254);
        check("e_closing_254", 32'(state_dbg), 32'(ST_CLOSING));
        tick(1);
        check("e_fault_state", 32'(state_dbg), 32'(ST_FAULT));
        check("e_fault_outputs", {27'd0, engine, door, fault}, 1);
        press(8'hFF);
        check("e_buttons_ignored", 32'(pending), 32'h08);
        sensor_door = 2'd2;
        tick(3);
        check("e_fault_held", 32'(state_dbg), 32'(ST_FAULT));

        // Top floor: stray sensor_up while opening is ignored; sensor_up while moving down faults.
        do_reset();
        press(8'h80);
        tick(2);
        for (int k = 0; k < 7; k++) pulse_up();
        check("f_floor7", 32'(floor), 7);
        pulse_up();
        check("f_ignored_floor", 32'(floor), 7);
        check("f_ignored_state", 32'(state_dbg), 32'(ST_OPENING));
        sensor_door = 2'd1;
        tick(1);
        press(8'h04);
        tick(15);
        tick(1);
        sensor_door = 2'd2;
        tick(1);
        check("f_move_down", 32'(state_dbg), 32'(ST_MOVE_DOWN));
        sensor_up = 1'b1;
        tick(1);
        sensor_up = 1'b0;
        check("f_wrong_dir_fault", 32'(state_dbg), 32'(ST_FAULT));
        check("f_floor_kept", 32'(floor), 7);
        check("f_engine_off", 32'(engine), 0);

        // sensor_down while moving up faults, floor unchanged.
        do_reset();
        press(8'h08);
        tick(2);
        pulse_up();
        sensor_down = 1'b1;
        tick(1);
        sensor_down = 1'b0;
        check("g_fault", 32'(fault), 1);
        check("g_floor_kept", 32'(floor), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/elevator_controller.md
ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

Interface
REQ-001 SHALL have parameter BUTTONS_WIDTH, default 8, number of floors; one call button per floor.
REQ-002 SHALL have parameter DOOR_DWELL, default 16, cycles the door stays open before it may close.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles allowed in OPENING, CLOSING or between floor sensors while moving.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port buttons  input  BUTTONS_WIDTH  bit i high = call for floor i; any pulse length.
REQ-007 SHALL have port sensor_up  input  1  one-cycle pulse: cabin crossed into the next floor upward.
REQ-008 SHALL have port sensor_down  input  1  one-cycle pulse: cabin crossed into the next floor downward.
REQ-009 SHALL have port sensor_door  input  2  0 between, 1 fully open, 2 fully closed.
REQ-010 SHALL have port engine  output  2  0 idle, 1 down, 2 up.
REQ-011 SHALL have port door  output  2  0 idle, 1 open, 2 close.
REQ-012 SHALL have port floor  output  $clog2(BUTTONS_WIDTH)  current floor index.
REQ-013 SHALL have port pending  output  BUTTONS_WIDTH  latched outstanding calls.
REQ-014 SHALL have port fault  output  1  high when in FAULT.

Function
REQ-015 SHALL latch buttons[i] into pending[i] on the next edge (OR-accumulate); pending bit stays set until served.
REQ-016 SHALL implement states IDLE, CLOSING, MOVE_UP, MOVE_DOWN, OPENING, DWELL, FAULT; engine/door are Moore decodes of state: CLOSING door=2, OPENING door=1, MOVE_UP engine=2, MOVE_DOWN engine=1, all others 0.
REQ-017 SHALL keep a direction register dir (up/down), reset to up.
REQ-018 IDLE: pending[floor] -> OPENING; else calls beyond floor in dir -> CLOSING in dir; else calls opposite -> flip dir, CLOSING; else stay IDLE.
REQ-019 CLOSING: on sensor_door==2 -> MOVE_UP or MOVE_DOWN per dir; closing already-closed door exits next cycle.
REQ-020 MOVE_UP: on sensor_up, floor <= floor+1; if pending[floor+1] -> OPENING same edge; MOVE_DOWN symmetric with sensor_down and floor-1.
REQ-021 OPENING: on sensor_door==1 -> DWELL, clear pending[floor], load dwell counter with DOOR_DWELL.
REQ-022 DWELL: decrement counter; at 0 -> IDLE; door left open in IDLE until a move is needed.
REQ-023 A button for the current floor during OPENING or DWELL SHALL NOT set pending and SHALL reload the dwell counter in DWELL.
REQ-024 Button set and served-clear of the same bit on the same edge: clear wins only per REQ-023; other bits latch normally.
REQ-025 Timeout counter SHALL reset on every state change and floor sensor pulse; reaching TIMEOUT in CLOSING, OPENING, MOVE_UP or MOVE_DOWN -> FAULT.
REQ-026 sensor_up at top floor, sensor_down at floor 0, sensor_up in MOVE_DOWN, or sensor_down in MOVE_UP SHALL -> FAULT; floor unchanged.
REQ-027 Floor sensors outside MOVE_UP/MOVE_DOWN SHALL be ignored.
REQ-028 FAULT: engine=0, door=0, fault=1, buttons ignored, pending held; exit only by reset.

Reset
REQ-029 While reset is low: state IDLE, dir up, floor 0, pending 0, engine 0, door 0, fault 0, all counters 0; asserting reset mid-move SHALL stop engine immediately (asynchronously).
REQ-030 First edge after reset release SHALL evaluate IDLE with pending 0.

Verification
REQ-031 Reset, sensor_door=2, pulse buttons[3] -> pending=0x08, CLOSING, engine=2, three sensor_up pulses -> floor=3, door=1, sensor_door=1 -> pending=0, DWELL 16 cycles, IDLE.
REQ-032 At floor 2 moving up with pending {5,0}: serve 5 first, then dir flips, serve 0; engine never reverses before floor 5 served.
REQ-033 In DWELL at floor 4, press buttons[4] at counter=2 -> dwell restarts at 16, pending[4] stays 0.
REQ-034 CLOSING with sensor_door held 0 for 255 cycles -> FAULT, fault=1, engine=0, door=0; buttons ignored until reset.
REQ-035 MOVE_UP at floor 7 (top) plus sensor_up -> FAULT, floor stays 7; sensor_down during MOVE_UP -> FAULT.
REQ-036 Assert reset mid MOVE_DOWN -> engine=0 without clock edge, floor=0, pending=0.
